// File: rtl/fb_mem_arbiter.sv
// Two-port round-robin arbiter with lock, in front of a single-port 1-cycle-latency RAM.
// Define ARB_FIXED_PRIO_EN to make P0 win contention (the lock rule still applies).
module fb_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     lock0,
  input  logic                     lock1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_we,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_e;

  owner_e owner_q, owner_d;
  logic   lock_q, lock_d;
  logic   rvalid0_q, rvalid0_d;
  logic   rvalid1_q, rvalid1_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q   <= OWN_NONE;
      lock_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      lock_q    <= lock_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  always_comb begin
    owner_d   = owner_q;
    lock_d    = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (!rst) begin
      gnt0 = 1'b0;
    end else if (lock_q && owner_q == OWN_P0 && req0) begin
      gnt0 = 1'b1;
    end else if (lock_q && owner_q == OWN_P1 && req1) begin
      gnt1 = 1'b1;
    end else if (req0 && !req1) begin
      gnt0 = 1'b1;
    end else if (req1 && !req0) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
      gnt0 = 1'b1;
`else
      // Strict alternation: only a P0 owner yields to P1.
      if (owner_q == OWN_P0) gnt1 = 1'b1;
      else                   gnt0 = 1'b1;
`endif
    end
    if (gnt0) begin
      owner_d   = OWN_P0;
      lock_d    = lock0;
      ram_addr  = addr0;
      ram_we    = we0;
      ram_wdata = wdata0;
    end else if (gnt1) begin
      owner_d   = OWN_P1;
      lock_d    = lock1;
      ram_addr  = addr1;
      ram_we    = we1;
      ram_wdata = wdata1;
    end
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
  end

  // Gate with rst so a reset landing on the response cycle suppresses it.
  assign rvalid0 = rvalid0_q & rst;
  assign rvalid1 = rvalid1_q & rst;
  assign rdata   = ram_rdata;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed table-driven bench for fb_mem_arbiter with a behavioural read-before-write RAM.
module tb_fb_mem_arbiter;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, lock0, lock1, we0, we1;
  logic [5:0] addr0, addr1;
  logic [9:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [9:0] rdata;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [9:0] ram_wdata;
  logic [9:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_mem_arbiter #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Read-before-write RAM; preloaded on the first edge (mem[50]=5, rest 0).
  logic [9:0] mem [64];
  logic       init = 1'b1;
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i == 50) ? 10'd5 : 10'd0;
    end else begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
  end

  typedef struct {
    logic       r0, r1, l0, l1, w0, w1;
    logic [5:0] a0, a1;
    logic [9:0] d0, d1;
    logic       g0, g1, v0, v1;
    logic [9:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r0, logic r1, logic l0, logic l1, logic w0, logic w1,
                              logic [5:0] a0, logic [5:0] a1, logic [9:0] d0, logic [9:0] d1,
                              logic g0, logic g1, logic v0, logic v1, logic [9:0] rd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic r1, input logic l0, input logic l1,
                       input logic w0, input logic w1, input logic [5:0] a0, input logic [5:0] a1,
                       input logic [9:0] d0, input logic [9:0] d1);
    req0 = r0; req1 = r1; lock0 = l0; lock1 = l1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 6'd50, 6'd7, 10'd0, 10'd0);

    // Contention 4 cycles, idle, then solo read, RAW, read-before-write, lock.
    vecs.push_back(mk(1,1,0,0,0,0,50,7,0,0, 1,0, 0,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,50,7,0,0, FP,!FP, 1,0,5));
    vecs.push_back(mk(1,1,0,0,0,0,50,7,0,0, 1,0, FP,!FP,FP ? 10'd5 : 10'd0));
    vecs.push_back(mk(1,1,0,0,0,0,50,7,0,0, FP,!FP, 1,0,5));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0, FP,!FP,FP ? 10'd5 : 10'd0));
    vecs.push_back(mk(1,0,0,0,0,0,50,0,0,0, 1,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0, 1,0,5));
    vecs.push_back(mk(1,0,0,0,1,0,3,0,10'h240,0, 1,0, 0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,3,0,0, 0,1, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0, 0,1,10'h240));
    vecs.push_back(mk(0,1,0,0,0,0,0,3,0,0, 0,1, 0,0,0));
    vecs.push_back(mk(1,0,0,0,1,0,3,0,10'h111,0, 1,0, 0,1,10'h240));
    vecs.push_back(mk(0,1,0,0,0,0,0,3,0,0, 0,1, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0, 0,1,10'h111));
    vecs.push_back(mk(0,1,0,1,0,1,0,52,0,15, 0,1, 0,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,50,52,0,0, 0,1, 0,0,0));
    vecs.push_back(mk(1,0,1,0,0,0,50,0,0,0, 1,0, 0,1,15));
    vecs.push_back(mk(1,1,0,0,0,0,50,7,0,0, 1,0, 1,0,5));
    vecs.push_back(mk(1,1,0,0,0,0,50,7,0,0, FP,!FP, 1,0,5));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0, FP,!FP,FP ? 10'd5 : 10'd0));

    // Reset with both requesting: everything quiet.
    @(posedge clk); #1 init = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_rv", {rvalid0, rvalid1}, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_addr", ram_addr, 0);
      @(posedge clk); #1;
    end
    rst = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      logic [5:0] ea;
      logic       ew;
      logic [9:0] ed;
      v = vecs[i];
      drive(v.r0, v.r1, v.l0, v.l1, v.w0, v.w1, v.a0, v.a1, v.d0, v.d1);
      ea = v.g0 ? v.a0 : (v.g1 ? v.a1 : 6'd0);
      ew = v.g0 ? v.w0 : (v.g1 ? v.w1 : 1'b0);
      ed = v.g0 ? v.d0 : (v.g1 ? v.d1 : 10'd0);
      @(negedge clk);
      chk($sformatf("v%0d_gnt0", i), gnt0, v.g0);
      chk($sformatf("v%0d_gnt1", i), gnt1, v.g1);
      chk($sformatf("v%0d_rv0", i), rvalid0, v.v0);
      chk($sformatf("v%0d_rv1", i), rvalid1, v.v1);
      chk($sformatf("v%0d_ram_addr", i), ram_addr, ea);
      chk($sformatf("v%0d_ram_we", i), ram_we, ew);
      chk($sformatf("v%0d_ram_wdata", i), ram_wdata, ed);
      if (v.v0 || v.v1) chk($sformatf("v%0d_rdata", i), rdata, v.rd);
      @(posedge clk); #1;
    end

    // Mid-access reset: read granted, then reset lands on its response cycle.
    drive(1, 0, 0, 0, 0, 0, 6'd50, 6'd0, 10'd0, 10'd0);
    @(negedge clk);
    chk("mr_gnt0", gnt0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 6'd50, 6'd7, 10'd0, 10'd0);
    @(negedge clk);
    chk("mr_rv0", rvalid0, 0);
    chk("mr_rv1", rvalid1, 0);
    chk("mr_gnt", {gnt0, gnt1}, 0);
    chk("mr_we", ram_we, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mr_post_gnt0", gnt0, 1);
    chk("mr_post_gnt1", gnt1, 0);
    chk("mr_post_rv0", rvalid0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 6'd0, 6'd0, 10'd0, 10'd0);
    @(negedge clk);
    chk("mr_post_rvalid0", rvalid0, 1);
    chk("mr_post_rdata", rdata, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
